// File: rtl/io_panel.sv
// io_panel: board-side I/O front end.
// Debounces 16 raw switch lines into the core input word and scans the
// 12-bit core output word as 3 hex digits on a 4-digit multiplexed display.
module io_panel #(
   parameter int unsigned DEB_CYCLES  = 50000,
   parameter int unsigned SCAN_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] io_word,
   input  logic [15:0] sw_raw,
   output logic [15:0] io_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp
);

   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
   localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

   // Active-low hex decode, segment order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Input path state
   logic [15:0]       sync1_q, sync2_q;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [15:0]       hist0_q, hist1_q, hist2_q;
   logic [15:0]       hist0_d, hist1_d, hist2_d;
   logic [15:0]       io_in_q, io_in_d;
   logic [15:0]       agree_c;
   logic              tick_c;

   // Display path state
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        digit_q, digit_d;
   logic [11:0]       shadow_q, shadow_d;
   logic              load_q, load_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              scan_last_c;

   // Debounce: shift history on tick, accept a bit only when all 3 samples agree
   always_comb begin
      tick_c    = (deb_cnt_q == DEB_LAST);
      deb_cnt_d = tick_c ? '0 : deb_cnt_q + DEB_W'(1);
      hist0_d   = hist0_q;
      hist1_d   = hist1_q;
      hist2_d   = hist2_q;
      if (tick_c) begin
         hist0_d = sync2_q;
         hist1_d = hist0_q;
         hist2_d = hist1_q;
      end
      // Judging the next history lets acceptance land on the third tick edge itself
      agree_c = ~(hist0_d ^ hist1_d) & ~(hist1_d ^ hist2_d);
      io_in_d = (agree_c & hist0_d) | (~agree_c & io_in_q);
   end

   // Scan: advance slot counter/digit, latch shadow at frame start, decode registered drive
   always_comb begin
      scan_last_c = (scan_cnt_q == SCAN_LAST);
      scan_cnt_d  = scan_cnt_q;
      digit_d     = digit_q;
      shadow_d    = shadow_q;
      load_d      = 1'b0;
      an_d        = 4'hF;
      seg_d       = 7'h7F;
      if (load_q) begin
         // First cycle after reset: capture the word, keep display dark, hold the scan
         shadow_d = io_word;
      end else begin
         scan_cnt_d = scan_last_c ? '0 : scan_cnt_q + SCAN_W'(1);
         if (scan_last_c) begin
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
               shadow_d = io_word;
            end
         end
         case (digit_q)
            2'd0: begin an_d = 4'hE; seg_d = hex7(shadow_q[3:0]);  end
            2'd1: begin an_d = 4'hD; seg_d = hex7(shadow_q[7:4]);  end
            2'd2: begin an_d = 4'hB; seg_d = hex7(shadow_q[11:8]); end
            default: begin an_d = 4'hF; seg_d = 7'h7F; end
         endcase
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_cnt_q  <= '0;
         hist0_q    <= '0;
         hist1_q    <= '0;
         hist2_q    <= '0;
         io_in_q    <= '0;
         scan_cnt_q <= '0;
         digit_q    <= '0;
         shadow_q   <= '0;
         load_q     <= 1'b1;
         an_q       <= 4'hF;
         seg_q      <= 7'h7F;
      end else begin
         sync1_q    <= sw_raw;
         sync2_q    <= sync1_q;
         deb_cnt_q  <= deb_cnt_d;
         hist0_q    <= hist0_d;
         hist1_q    <= hist1_d;
         hist2_q    <= hist2_d;
         io_in_q    <= io_in_d;
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
         shadow_q   <= shadow_d;
         load_q     <= load_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign io_in = io_in_q;
   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = 1'b1;

endmodule

// File: tb/tb_io_panel.sv
// tb_io_panel: directed bench for io_panel with a slot scoreboard for the display.
module tb_io_panel;

   localparam int unsigned DEB  = 4;
   localparam int unsigned SCAN = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] io_word;
   logic [15:0] sw_raw;
   logic [15:0] io_in;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } slot_t;

   slot_t exp_q[$];

   io_panel #(.DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_word (io_word),
      .sw_raw  (sw_raw),
      .io_in   (io_in),
      .seg     (seg),
      .an      (an),
      .dp      (dp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   // Expected display frame for a latched word: digits 0,1,2 then the blank slot
   task automatic push_frame(input logic [11:0] w);
      exp_q.push_back('{an: 4'hE, seg: hex7(w[3:0])});
      exp_q.push_back('{an: 4'hD, seg: hex7(w[7:4])});
      exp_q.push_back('{an: 4'hB, seg: hex7(w[11:8])});
      exp_q.push_back('{an: 4'hF, seg: 7'h7F});
   endtask

   // Called on the first visible cycle of a slot; measures it and returns at the next slot
   task automatic next_slot(input string tag);
      slot_t o;
      slot_t e;
      int    len;
      o   = '{an: an, seg: seg};
      len = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ({an, seg} !== o) break;
         len++;
      end
      check({tag, " queue"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, " an"},  32'(o.an),  32'(e.an));
         check({tag, " seg"}, 32'(o.seg), 32'(e.seg));
      end
      check({tag, " len"}, 32'(len), 32'(SCAN));
   endtask

   initial begin
      bit found;

      // Reset held with all inputs high
      rst     = 1'b1;
      sw_raw  = 16'hFFFF;
      io_word = 12'hFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst io_in", 32'(io_in), 32'h0);
         check("rst an",    32'(an),    32'hF);
         check("rst seg",   32'(seg),   32'h7F);
         check("rst dp",    32'(dp),    32'h1);
      end
      rst     = 1'b0;
      sw_raw  = 16'h0000;
      io_word = 12'h3A5;
      @(negedge clk);
      check("post-rel io_in", 32'(io_in), 32'h0);
      check("post-rel an",    32'(an),    32'hF);
      check("post-rel seg",   32'(seg),   32'h7F);
      check("post-rel dp",    32'(dp),    32'h1);

      // Display scan, with io_word changed during digit 1 of the first frame
      push_frame(12'h3A5);
      push_frame(12'h000);
      @(negedge clk);
      next_slot("f1 d0");
      io_word = 12'h000;
      next_slot("f1 d1");
      next_slot("f1 d2");
      next_slot("f1 blank");
      next_slot("f2 d0");
      next_slot("f2 d1");
      next_slot("f2 d2");
      next_slot("f2 blank");
      check("dp idle", 32'(dp), 32'h1);

      // Held input on bit 0
      sw_raw[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("hold early", 32'(io_in), 32'h0);
      end
      repeat (6) @(negedge clk);
      check("accept bit0", 32'(io_in), 32'h0001);

      // Short glitch on bit 5 must be rejected
      sw_raw[5] = 1'b1;
      repeat (6) @(negedge clk);
      sw_raw[5] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("glitch bit5", 32'(io_in), 32'h0001);
      end

      // Release of bit 0
      sw_raw[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("release early", 32'(io_in), 32'h0001);
      repeat (6) @(negedge clk);
      check("release bit0", 32'(io_in), 32'h0000);

      // Reset during digit 2 with io_in set
      sw_raw[0] = 1'b1;
      repeat (14) @(negedge clk);
      check("re-accept bit0", 32'(io_in), 32'h0001);
      found = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (an === 4'hB) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reach digit2", 32'(found), 32'h1);
      rst     = 1'b1;
      sw_raw  = 16'h0000;
      io_word = 12'h7C1;
      @(negedge clk);
      check("midrst an",    32'(an),    32'hF);
      check("midrst seg",   32'(seg),   32'h7F);
      check("midrst io_in", 32'(io_in), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("restart load an", 32'(an), 32'hF);
      exp_q.delete();
      push_frame(12'h7C1);
      @(negedge clk);
      next_slot("r d0");
      next_slot("r d1");
      next_slot("r d2");
      next_slot("r blank");
      check("restart io_in", 32'(io_in), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
